i_sync_filter: RTL and testbench
================================

# i_sync_filter

Input conditioning stage placed directly downstream of the input buffer: takes the buffer's asynchronous pad-side data output, synchronizes it into the fabric clock domain and suppresses glitches shorter than a programmable number of cycles. Produces a clean, registered level plus optional single-cycle edge strobes for fabric logic (interrupt lines, strobes, slow control pins).

## Interface
- SYNC_STAGES, 2, synchronizer flop count; legal 2..4.
- FILTER_CYCLES, 4, consecutive stable cycles required before O changes; legal 1..255.
- INIT_VALUE, 1'b0, reset value of synchronizer flops and O.
- Illegal SYNC_STAGES / FILTER_CYCLES / INIT_VALUE (not 0/1) -> `$fatal` in initial block naming instance `%m` and the legal range.

- C  input  1  clock; all state on rising edge.
- R  input  1  reset, asynchronous, active-high.
- I  input  1  asynchronous data from input buffer O.
- EN  input  1  filter enable; synchronous.
- O  output  1  filtered, synchronized level.
- BUSY  output  1  high while a pending transition is being qualified (counter != 0).
- RISE  output  1  one-cycle strobe on O 0->1.
- FALL  output  1  one-cycle strobe on O 1->0.

## Operation
- Synchronizer: shift chain s[0..SYNC_STAGES-1], s[0] <= I each edge; runs regardless of EN. Synced value S = s[SYNC_STAGES-1].
- Qualifier: 8-bit counter CNT.
  - EN=0: CNT <= 0, O holds.
  - EN=1, S == O: CNT <= 0 (glitch rejected / idle).
  - EN=1, S != O, CNT == FILTER_CYCLES-1: O <= S, CNT <= 0.
  - EN=1, S != O, otherwise: CNT <= CNT+1.
- Effective two-state machine: IDLE (CNT=0, S==O) and QUALIFY (CNT>0); BUSY = (CNT != 0), combinational from CNT register.
- Any return of S to O during QUALIFY restarts qualification from zero; no partial credit.
- EN deassertion mid-QUALIFY aborts; re-qualification starts from zero when EN returns.
- RISE/FALL registered: asserted in the cycle O holds its new value, exactly one cycle.
- CNT never exceeds FILTER_CYCLES-1; no wrap.

## Timing
- Reset (R=1, async): all s[] = INIT_VALUE, O = INIT_VALUE, CNT = 0, BUSY = 0, RISE = FALL = 0. Release is taken synchronously on next edge; no strobe generated on reset exit.
- Latency: I stable and set up before edge 1 (sampling edge) -> O updates at edge SYNC_STAGES+FILTER_CYCLES, given EN=1 throughout. Defaults: edge 6.
- FILTER_CYCLES=1: O updates on the first edge at which S != O is seen (edge SYNC_STAGES+1).
- Minimum accepted pulse at S: FILTER_CYCLES cycles; shorter pulses never reach O.
- Minimum O period between opposite transitions: FILTER_CYCLES cycles.
- I metastability handled only by the chain; I has no setup requirement.

## Configuration
- Macro `I_SYNC_FILTER_EDGE_EN`.
- Defined: RISE/FALL flops and logic present as specified.
- Undefined: RISE and FALL ports remain, tied constant 0; no edge flops instantiated. O, BUSY, latency unchanged.

## Test plan
- Reset: assert R with I=1, INIT_VALUE=0 -> O=0, BUSY=0, RISE=FALL=0 immediately (async, before any clock edge).
- Clean rise, defaults: I 0->1 before edge 1, EN=1 -> BUSY high edges 3..5, O=1 at edge 6, RISE=1 for exactly that cycle (with macro), 0 without macro.
- Glitch rejection, defaults: I high for 3 cycles then low -> O stays 0, BUSY pulses then returns 0, no RISE.
- Boundary: I high exactly 4 cycles (FILTER_CYCLES=4) -> O rises once, then falls after I low 4 cycles, FALL strobes once; FILTER_CYCLES=1, SYNC_STAGES=3 -> O follows I at edge 4.
- EN abort: I rises, drop EN at edge 4, hold 2 cycles, restore -> CNT restarts; O=1 exactly 4 edges after EN returns.
- Reset mid-QUALIFY: assert R at edge 4 of a rise -> O=INIT_VALUE, BUSY=0 instantly; after release with I still 1, O rises at edge SYNC_STAGES+FILTER_CYCLES post-release.

Source files
------------

// File: rtl/i_sync_filter.sv
// rtl/i_sync_filter.sv - input synchronizer with programmable glitch filter and edge strobes
// Optional RISE/FALL strobe flops enabled by macro I_SYNC_FILTER_EDGE_EN.
module i_sync_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int INIT_VALUE    = 1'b0
) (
    input  logic C,
    input  logic R,
    input  logic I,
    input  logic EN,
    output logic O,
    output logic BUSY,
    output logic RISE,
    output logic FALL
);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $fatal(1, "%m: SYNC_STAGES=%0d illegal, legal range 2..4", SYNC_STAGES);
        end
        if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_filter
            $fatal(1, "%m: FILTER_CYCLES=%0d illegal, legal range 1..255", FILTER_CYCLES);
        end
        if (INIT_VALUE < 0 || INIT_VALUE > 1) begin : g_bad_init
            $fatal(1, "%m: INIT_VALUE=%0d illegal, legal values 0..1", INIT_VALUE);
        end
    endgenerate

    localparam logic       INIT_BIT = 1'(INIT_VALUE);
    localparam logic [7:0] CNT_MAX  = 8'(FILTER_CYCLES - 1);

    typedef enum logic {
        IDLE,
        QUALIFY
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic                   o_q, o_d;
    logic [7:0]             cnt_q, cnt_d;
    state_t                 state_q, state_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            sync_q  <= {SYNC_STAGES{INIT_BIT}};
            o_q     <= INIT_BIT;
            cnt_q   <= 8'd0;
            state_q <= IDLE;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], I};
            o_q     <= o_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Any return of S to O, or EN low, discards all accumulated qualification.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (EN && (sync_s != o_q)) begin
                    if (CNT_MAX == 8'd0) begin
                        o_d = sync_s;
                    end else begin
                        cnt_d   = 8'd1;
                        state_d = QUALIFY;
                    end
                end
            end
            QUALIFY: begin
                if (!EN || (sync_s == o_q)) begin
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    o_d     = sync_s;
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = IDLE;
            end
        endcase
    end

    assign O    = o_q;
    assign BUSY = (cnt_q != 8'd0);

`ifdef I_SYNC_FILTER_EDGE_EN
    logic rise_q, fall_q;

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= o_d & ~o_q;
            fall_q <= ~o_d & o_q;
        end
    end

    assign RISE = rise_q;
    assign FALL = fall_q;
`else
    assign RISE = 1'b0;
    assign FALL = 1'b0;
`endif

endmodule

// File: tb/tb_i_sync_filter.sv
// tb/tb_i_sync_filter.sv - directed self-checking bench for i_sync_filter
module tb_i_sync_filter;

`ifdef I_SYNC_FILTER_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic C = 1'b0;
    logic R = 1'b1;
    logic I = 1'b0;
    logic EN = 1'b1;
    logic I1 = 1'b0;
    logic EN1 = 1'b1;
    logic O, BUSY, RISE, FALL;
    logic O1, BUSY1, RISE1, FALL1;

    int asserts = 0;
    int failures = 0;

    always #5 C = ~C;

    i_sync_filter dut (
        .C(C), .R(R), .I(I), .EN(EN),
        .O(O), .BUSY(BUSY), .RISE(RISE), .FALL(FALL)
    );

    i_sync_filter #(.SYNC_STAGES(3), .FILTER_CYCLES(1), .INIT_VALUE(0)) dut1 (
        .C(C), .R(R), .I(I1), .EN(EN1),
        .O(O1), .BUSY(BUSY1), .RISE(RISE1), .FALL(FALL1)
    );

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic test_reset();
        R = 1'b1; I = 1'b1; I1 = 1'b1; EN = 1'b1;
        #1;
        asserts++; if (O !== 1'b0) begin failures++; $display("FAIL reset_O got=%b exp=0", O); end
        asserts++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_BUSY got=%b exp=0", BUSY); end
        asserts++; if (RISE !== 1'b0) begin failures++; $display("FAIL reset_RISE got=%b exp=0", RISE); end
        asserts++; if (FALL !== 1'b0) begin failures++; $display("FAIL reset_FALL got=%b exp=0", FALL); end
        asserts++; if (O1 !== 1'b0) begin failures++; $display("FAIL reset_O1 got=%b exp=0", O1); end
        tick(); tick();
        I = 1'b0; I1 = 1'b0;
        tick(); tick();
        R = 1'b0;
        for (int e = 1; e <= 6; e++) tick();
        asserts++; if (O !== 1'b0 || BUSY !== 1'b0 || RISE !== 1'b0) begin
            failures++; $display("FAIL reset_exit O=%b BUSY=%b RISE=%b exp=000", O, BUSY, RISE);
        end
    endtask

    task automatic test_clean_rise();
        I = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            asserts++; if (BUSY !== (e >= 3 && e <= 5)) begin failures++; $display("FAIL rise_BUSY e=%0d got=%b", e, BUSY); end
            asserts++; if (O !== (e >= 6)) begin failures++; $display("FAIL rise_O e=%0d got=%b", e, O); end
            asserts++; if (RISE !== (EDGE_EN && e == 6)) begin failures++; $display("FAIL rise_RISE e=%0d got=%b", e, RISE); end
        end
    endtask

    task automatic test_clean_fall();
        I = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            asserts++; if (O !== (e < 6)) begin failures++; $display("FAIL fall_O e=%0d got=%b", e, O); end
            asserts++; if (FALL !== (EDGE_EN && e == 6)) begin failures++; $display("FAIL fall_FALL e=%0d got=%b", e, FALL); end
            asserts++; if (RISE !== 1'b0) begin failures++; $display("FAIL fall_RISE e=%0d got=%b exp=0", e, RISE); end
        end
    endtask

    task automatic test_glitch();
        I = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 3) I = 1'b0;
            asserts++; if (BUSY !== (e >= 3 && e <= 5)) begin failures++; $display("FAIL glitch_BUSY e=%0d got=%b", e, BUSY); end
            asserts++; if (O !== 1'b0) begin failures++; $display("FAIL glitch_O e=%0d got=%b exp=0", e, O); end
            asserts++; if (RISE !== 1'b0) begin failures++; $display("FAIL glitch_RISE e=%0d got=%b exp=0", e, RISE); end
        end
    endtask

    task automatic test_boundary();
        I = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 4) I = 1'b0;
            asserts++; if (O !== (e >= 6 && e <= 9)) begin failures++; $display("FAIL bound_O e=%0d got=%b", e, O); end
            asserts++; if (BUSY !== ((e >= 3 && e <= 5) || (e >= 7 && e <= 9))) begin
                failures++; $display("FAIL bound_BUSY e=%0d got=%b", e, BUSY);
            end
            asserts++; if (RISE !== (EDGE_EN && e == 6)) begin failures++; $display("FAIL bound_RISE e=%0d got=%b", e, RISE); end
            asserts++; if (FALL !== (EDGE_EN && e == 10)) begin failures++; $display("FAIL bound_FALL e=%0d got=%b", e, FALL); end
        end
    endtask

    task automatic test_en_abort();
        I = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 3) EN = 1'b0;
            if (e == 5) EN = 1'b1;
            asserts++; if (O !== (e >= 9)) begin failures++; $display("FAIL abort_O e=%0d got=%b", e, O); end
            asserts++; if (BUSY !== (e == 3 || (e >= 6 && e <= 8))) begin
                failures++; $display("FAIL abort_BUSY e=%0d got=%b", e, BUSY);
            end
        end
        I = 1'b0;
        for (int e = 1; e <= 8; e++) tick();
        asserts++; if (O !== 1'b0) begin failures++; $display("FAIL abort_settle_O got=%b exp=0", O); end
    endtask

    task automatic test_reset_mid();
        I = 1'b1;
        for (int e = 1; e <= 4; e++) tick();
        asserts++; if (BUSY !== 1'b1) begin failures++; $display("FAIL rmid_pre_BUSY got=%b exp=1", BUSY); end
        R = 1'b1;
        #1;
        asserts++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rmid_BUSY got=%b exp=0", BUSY); end
        asserts++; if (O !== 1'b0) begin failures++; $display("FAIL rmid_O got=%b exp=0", O); end
        tick();
        R = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            asserts++; if (O !== (e >= 6)) begin failures++; $display("FAIL rmid_post_O e=%0d got=%b", e, O); end
            asserts++; if (RISE !== (EDGE_EN && e == 6)) begin failures++; $display("FAIL rmid_RISE e=%0d got=%b", e, RISE); end
        end
    endtask

    task automatic test_fc1();
        I1 = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            asserts++; if (O1 !== (e >= 4)) begin failures++; $display("FAIL fc1_O e=%0d got=%b", e, O1); end
            asserts++; if (BUSY1 !== 1'b0) begin failures++; $display("FAIL fc1_BUSY e=%0d got=%b exp=0", e, BUSY1); end
            asserts++; if (RISE1 !== (EDGE_EN && e == 4)) begin failures++; $display("FAIL fc1_RISE e=%0d got=%b", e, RISE1); end
        end
        I1 = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            asserts++; if (O1 !== (e < 4)) begin failures++; $display("FAIL fc1_fall_O e=%0d got=%b", e, O1); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_clean_fall();
        test_glitch();
        test_boundary();
        test_en_abort();
        test_reset_mid();
        test_fc1();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
